// File: rtl/reg_wb_pkg.sv
// Shared types for the register-file writeback controller.
// Default widths, load-queue pointer and write-request bundle.
package reg_wb_pkg;

  localparam int WB_DATA_W   = 32;
  localparam int WB_ADDR_W   = 5;
  localparam int WB_LQ_DEPTH = 4;
  localparam int WB_LQ_PTR_W = $clog2(WB_LQ_DEPTH);

  typedef logic [WB_LQ_PTR_W-1:0] lq_ptr_t;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_load_fifo.sv
// In-order FIFO of pending load destinations.
// Exposes every slot plus occupancy so the owner can scan for busy registers.
module wb_load_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = WB_LQ_DEPTH,
  parameter int AW    = WB_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [AW-1:0]            push_rd,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [AW-1:0]            head,
  output logic [DEPTH-1:0][AW-1:0] slot_rd,
  output logic [DEPTH-1:0]         slot_occ
);

  localparam int CW = $clog2(DEPTH) + 1;

  lq_ptr_t                  wr_ptr;
  lq_ptr_t                  rd_ptr;
  logic [CW-1:0]            count;
  logic [DEPTH-1:0][AW-1:0] mem;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd_ptr];
  assign slot_rd = mem;

  // A slot is live when its distance from the head is below count.
  always_comb begin
    slot_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_occ[i] = {1'b0, lq_ptr_t'(i) - rd_ptr} < count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_rd;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write port arbiter with load busy scoreboard.
// REG_WB_FORWARD_EN adds a same-cycle bypass of the committing write.
module reg_writeback_ctrl
  import reg_wb_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int LQ_DEPTH = WB_LQ_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_issue_valid,
  output logic                 ld_issue_ready,
  input  logic [ADDR_W-1:0]    ld_issue_rd,
  input  logic                 ld_ret_valid,
  output logic                 ld_ret_ready,
  input  logic [DATA_W-1:0]    ld_ret_data,
  input  logic [ADDR_W-1:0]    chk_rs1,
  input  logic [ADDR_W-1:0]    chk_rs2,
  input  logic [ADDR_W-1:0]    chk_rd,
  output logic                 stall,
`ifdef REG_WB_FORWARD_EN
  output logic                 fwd1_hit,
  output logic                 fwd2_hit,
  output logic [DATA_W-1:0]    fwd_data,
`endif
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata
);

  localparam int NREG = 2**ADDR_W;

  logic                        lq_full;
  logic                        lq_empty;
  logic [ADDR_W-1:0]           lq_head;
  logic [LQ_DEPTH-1:0][ADDR_W-1:0] lq_slot;
  logic [LQ_DEPTH-1:0]         lq_occ;
  logic                        ld_issue_fire;
  logic                        ld_ret_fire;
  logic                        alu_fire;
  logic [NREG-1:0]             busy;
  logic                        we_d;
  wb_req_t                     wb_d;

  assign ld_issue_ready = !lq_full;
  assign ld_ret_ready   = !reset && !lq_empty;
  assign alu_ready      = !reset && !(ld_ret_valid && !lq_empty)
                          && !busy[alu_rd];

  assign ld_issue_fire = ld_issue_valid && ld_issue_ready;
  assign ld_ret_fire   = ld_ret_valid && ld_ret_ready;
  assign alu_fire      = alu_valid && alu_ready;

  wb_load_fifo #(
    .DEPTH (LQ_DEPTH),
    .AW    (ADDR_W)
  ) u_lq (
    .clk      (clk),
    .reset    (reset),
    .push     (ld_issue_fire),
    .push_rd  (ld_issue_rd),
    .pop      (ld_ret_fire),
    .full     (lq_full),
    .empty    (lq_empty),
    .head     (lq_head),
    .slot_rd  (lq_slot),
    .slot_occ (lq_occ)
  );

  // Busy is rebuilt from live queue slots, so duplicates keep a bit set.
  always_comb begin
    busy = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (lq_occ[i]) begin
        busy[lq_slot[i]] = 1'b1;
      end
    end
    busy[0] = 1'b0;
  end

  assign busy_mask = busy;
  assign stall     = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

  always_comb begin
    we_d = 1'b0;
    wb_d = '{addr: rf_waddr, data: rf_wdata};
    unique case (1'b1)
      ld_ret_fire: begin
        we_d = lq_head != '0;
        wb_d = '{addr: lq_head, data: ld_ret_data};
      end
      alu_fire: begin
        we_d = alu_rd != '0;
        wb_d = '{addr: alu_rd, data: alu_data};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we    <= we_d;
      rf_waddr <= wb_d.addr;
      rf_wdata <= wb_d.data;
    end
  end

`ifdef REG_WB_FORWARD_EN
  assign fwd1_hit = rf_we && rf_waddr == chk_rs1 && chk_rs1 != '0;
  assign fwd2_hit = rf_we && rf_waddr == chk_rs2 && chk_rs2 != '0;
  assign fwd_data = rf_wdata;
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl.
// Expected writes queue up at issue; a monitor pops them on rf_we.
module tb_reg_writeback_ctrl;
  import reg_wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue_valid, ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic        ld_ret_valid, ld_ret_ready;
  logic [31:0] ld_ret_data;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        stall;
  logic [31:0] busy_mask;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef REG_WB_FORWARD_EN
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd_data;
`endif

  reg_writeback_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_ready (ld_issue_ready),
    .ld_issue_rd    (ld_issue_rd),
    .ld_ret_valid   (ld_ret_valid),
    .ld_ret_ready   (ld_ret_ready),
    .ld_ret_data    (ld_ret_data),
    .chk_rs1        (chk_rs1),
    .chk_rs2        (chk_rs2),
    .chk_rd         (chk_rd),
    .stall          (stall),
`ifdef REG_WB_FORWARD_EN
    .fwd1_hit       (fwd1_hit),
    .fwd2_hit       (fwd2_hit),
    .fwd_data       (fwd_data),
`endif
    .busy_mask      (busy_mask),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata)
  );

  always #5 clk = ~clk;

  wb_req_t sb[$];
  wb_req_t mon_e;
  int      total = 0;
  int      bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    sb.push_back('{addr: a, data: d});
  endtask

  always @(negedge clk) begin
    if (!reset && rf_we) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got r%0d=%h want no write",
                 rf_waddr, rf_wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", {27'd0, rf_waddr}, {27'd0, mon_e.addr});
        chk("wr_data", rf_wdata, mon_e.data);
      end
    end
  end

  initial begin
    reset = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue_valid = 0; ld_issue_rd = 0;
    ld_ret_valid = 0; ld_ret_data = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    repeat (3) tick;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_ret_ready", ld_ret_ready, 0);
    chk("rst_issue_ready", ld_issue_ready, 1);
    chk("rst_stall", stall, 0);
    reset = 1'b0;
    tick;

    // plain ALU write
    alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF;
    #1 chk("t1_alu_ready", alu_ready, 1);
    expect_wr(3, 32'hDEADBEEF);
    tick;
    alu_valid = 0;
    chk("t1_we", rf_we, 1);
`ifdef REG_WB_FORWARD_EN
    chk_rs1 = 3;
    #1 chk("t1_fwd1", fwd1_hit, 1);
    chk("t1_fwd_data", fwd_data, 32'hDEADBEEF);
    chk_rs1 = 0;
`endif
    tick;

    // ALU blocked behind pending load to same rd
    ld_issue_valid = 1; ld_issue_rd = 5;
    #1 chk("t2_issue_ready", ld_issue_ready, 1);
    tick;
    ld_issue_valid = 0;
    chk("t2_busy", busy_mask, 32'h20);
    alu_valid = 1; alu_rd = 5; alu_data = 32'h55; chk_rs1 = 5;
    #1 chk("t2_alu_block", alu_ready, 0);
    chk("t2_stall", stall, 1);
    tick; tick;
    chk("t2_alu_block2", alu_ready, 0);
    ld_ret_valid = 1; ld_ret_data = 32'h1234;
    #1 chk("t2_ret_ready", ld_ret_ready, 1);
    expect_wr(5, 32'h1234);
    tick;
    ld_ret_valid = 0;
    #1 chk("t2_alu_free", alu_ready, 1);
    chk("t2_stall_clr", stall, 0);
    expect_wr(5, 32'h55);
    tick;
    alu_valid = 0; chk_rs1 = 0;
    tick;

    // load return beats ALU in the same cycle
    ld_issue_valid = 1; ld_issue_rd = 2;
    tick;
    ld_issue_valid = 0;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    ld_ret_valid = 1; ld_ret_data = 32'hAB;
    #1 chk("t3_alu_lose", alu_ready, 0);
    chk("t3_ret_ready", ld_ret_ready, 1);
    expect_wr(2, 32'hAB);
    tick;
    ld_ret_valid = 0;
    #1 chk("t3_alu_win", alu_ready, 1);
    expect_wr(7, 32'h77);
    tick;
    alu_valid = 0;
    tick;

    // fill queue, full+return, wrap
    for (int i = 0; i < 4; i++) begin
      ld_issue_valid = 1; ld_issue_rd = 5'(10 + i);
      #1 chk("t4_issue_ready", ld_issue_ready, 1);
      tick;
    end
    ld_issue_rd = 14;
    #1 chk("t4_full", ld_issue_ready, 0);
    ld_ret_valid = 1; ld_ret_data = 32'h100;
    #1 chk("t4_full_ret", ld_issue_ready, 0);
    expect_wr(10, 32'h100);
    tick;
    ld_ret_valid = 0;
    #1 chk("t4_not_full", ld_issue_ready, 1);
    tick;
    ld_issue_valid = 0;
    chk("t4_busy", busy_mask, 32'h7800);
    for (int i = 0; i < 4; i++) begin
      ld_ret_valid = 1; ld_ret_data = 32'h101 + i;
      #1 chk("t4_ret_ready", ld_ret_ready, 1);
      expect_wr(5'(11 + i), 32'h101 + i);
      tick;
    end
    ld_ret_valid = 0;
    chk("t4_busy_clr", busy_mask, 0);
    chk("t4_empty", ld_ret_ready, 0);

    // duplicate rd in queue
    ld_issue_valid = 1; ld_issue_rd = 9;
    tick; tick;
    ld_issue_valid = 0;
    ld_ret_valid = 1; ld_ret_data = 32'h900;
    expect_wr(9, 32'h900);
    tick;
    ld_ret_valid = 0;
    chk("t5_busy_dup", busy_mask, 32'h200);
    ld_ret_valid = 1; ld_ret_data = 32'h901;
    expect_wr(9, 32'h901);
    tick;
    ld_ret_valid = 0;
    chk("t5_busy_clr", busy_mask, 0);

    // same-cycle issue and return to the same rd
    ld_issue_valid = 1; ld_issue_rd = 6;
    tick;
    ld_ret_valid = 1; ld_ret_data = 32'h600;
    expect_wr(6, 32'h600);
    tick;
    ld_issue_valid = 0; ld_ret_valid = 0;
    chk("t5_set_wins", busy_mask, 32'h40);
    ld_ret_valid = 1; ld_ret_data = 32'h601;
    expect_wr(6, 32'h601);
    tick;
    ld_ret_valid = 0;
    chk("t5_set_clr", busy_mask, 0);

    // register 0 and empty-queue return
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
    #1 chk("t6_r0_ready", alu_ready, 1);
    tick;
    alu_valid = 0;
    chk("t6_r0_we", rf_we, 0);
    ld_ret_valid = 1; ld_ret_data = 32'hBAD;
    #1 chk("t6_empty_ret", ld_ret_ready, 0);
    tick;
    ld_ret_valid = 0;
    chk("t6_empty_we", rf_we, 0);

    // reset with loads in flight
    for (int i = 0; i < 3; i++) begin
      ld_issue_valid = 1; ld_issue_rd = 5'(20 + i);
      tick;
    end
    ld_issue_valid = 0;
    chk("t7_busy", busy_mask, 32'h700000);
    chk_rs2 = 21;
    #1 chk("t7_stall", stall, 1);
    reset = 1;
    tick;
    reset = 0;
    chk("t7_busy_clr", busy_mask, 0);
    chk("t7_stall_clr", stall, 0);
    chk("t7_issue_ready", ld_issue_ready, 1);
    chk_rs2 = 0;
    ld_ret_valid = 1; ld_ret_data = 32'hBAD;
    #1 chk("t7_ret_ready", ld_ret_ready, 0);
    tick;
    ld_ret_valid = 0;
    chk("t7_we", rf_we, 0);

    tick; tick;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
